// File: rtl/cross_bar_slave_mem.sv
// Memory-backed crossbar slave: one transaction at a time, programmable ack wait states,
// read data returned with a one-cycle resp pulse a fixed latency after ack.
module cross_bar_slave_mem #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 256,
    parameter int                ACK_WAIT   = 0,
    parameter int                RD_LATENCY = 2,
    parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              resp,
    output logic              err,
    output logic [2:0]        dbg_state_o
);

    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 16;

    // Handshake: master raises req with cmd/addr/wdata and holds it until it sees the
    // one-cycle ack; for reads, rdata is valid only in the single cycle resp is high.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACK     = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RESP    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                capture;
    logic                ack_q, err_q, resp_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                in_range;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >> (OFF + IDX_W)) == '0;
    endfunction

    assign idx      = addr_q[OFF +: IDX_W];
    assign in_range = addr_ok(addr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(ACK_WAIT);
                    state_d = (ACK_WAIT == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_ACK;
            end
            S_ACK: begin
                if (cmd_q) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = (RD_LATENCY == 1) ? S_RESP : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
            S_RESP:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == S_ACK);
            resp_q  <= (state_d == S_RESP);
            // In IDLE the address is not captured yet, so range-check the live input.
            err_q   <= (state_d == S_ACK) &&
                       !addr_ok((state_q == S_IDLE) ? addr : addr_q);
            if (capture) begin
                cmd_q   <= cmd;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Storage has no reset; an aborted ACK never reaches this edge because state_q clears.
    always_ff @(posedge aclk) begin
        if (state_q == S_ACK) begin
            if (cmd_q) begin
                if (in_range) mem[idx] <= wdata_q;
            end else begin
                rd_data_q <= in_range ? mem[idx] : ERR_DATA;
            end
        end
    end

    assign ack         = ack_q;
    assign err         = err_q;
    assign resp        = resp_q;
    assign rdata       = resp_q ? rd_data_q : '0;
    assign dbg_state_o = state_q;

endmodule
